cp0_unit: RTL

Parametrised system-control coprocessor (CP0) for the pipelined MIPS core. It sits beside the M stage and holds SR, Cause, EPC, PRId, BadVAddr and an optional Count/Compare timer. It arbitrates exceptions against hardware interrupts and drives the trap request and EPC to the PC logic. This generation adds a configurable interrupt-line count, address-error BadVAddr capture, an internal timer interrupt and eret handling.

---
 rtl/cp0_unit_if.sv | 41 ++++
 rtl/cp0_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cp0_unit_if.sv
// cp0_unit_if: pipeline-to-CP0 bus for the M stage.
// Carries the mfc0 read port, the mtc0 write port, the exception/eret
// status of the retiring instruction, the hardware interrupt lines and
// the trap request / EPC going back to the PC logic.
//
// Handshake semantics: there is no valid/ready pair on this bus. wr_en
// and eret are single-cycle strobes qualified by the rising clock edge,
// exc_code != 0 is the exception strobe, and int_req is a same-cycle
// acknowledge that the pipeline must honour (flush + redirect) in the
// cycle it is high. CP0 never stalls the pipeline.
interface cp0_unit_if #(
    parameter int NUM_IRQ = 6
);
    logic [4:0]         rd_addr;
    logic [31:0]        rd_data;
    logic [4:0]         wr_addr;
    logic [31:0]        wr_data;
    logic               wr_en;
    logic [31:0]        exc_pc;
    logic               exc_bd;
    logic [4:0]         exc_code;
    logic [31:0]        exc_badvaddr;
    logic [NUM_IRQ-1:0] hw_int;
    logic               eret;
    logic               int_req;
    logic [31:0]        epc;

    // Pipeline side: drives requests, consumes read data and the trap.
    modport master (
        output rd_addr, wr_addr, wr_data, wr_en,
        output exc_pc, exc_bd, exc_code, exc_badvaddr, hw_int, eret,
        input  rd_data, int_req, epc
    );

    // CP0 side.
    modport slave (
        input  rd_addr, wr_addr, wr_data, wr_en,
        input  exc_pc, exc_bd, exc_code, exc_badvaddr, hw_int, eret,
        output rd_data, int_req, epc
    );
endinterface

// File: rtl/cp0_unit.sv
// cp0_unit: system-control coprocessor beside the M stage.
// Holds SR, Cause, EPC, PRId, BadVAddr and, when the CP0_TIMER_EN macro
// is defined, the Count/Compare timer whose pending bit shows as Cause.TI
// and is OR'd into IP[TIMER_IRQ]. Without the macro registers 9 and 11
// read 0 and ignore writes.
// int_req is combinational: interrupts beat exceptions, and both are
// masked while SR.EXL is set. Trap updates win over a same-cycle mtc0.
module cp0_unit #(
    parameter int          NUM_IRQ   = 6,
    parameter logic [31:0] PRID_VAL  = 32'h2437_1277,
    parameter int          TIMER_IRQ = NUM_IRQ - 1
) (
    input  logic      clk,
    input  logic      reset,
    cp0_unit_if.slave bus
);
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_SR       = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    // SR bit positions used by the trap logic.
    localparam int SR_IE  = 0;
    localparam int SR_EXL = 1;

    logic [31:0]        sr_q;
    logic [31:0]        epc_q;
    logic [31:0]        badvaddr_q;
    logic               cause_bd_q;
    logic [4:0]         cause_code_q;
    logic [NUM_IRQ-1:0] cause_ip_q;
    logic               ti_q;

    logic [NUM_IRQ-1:0] ip_next;
    logic               irq;
    logic               exc;
    logic               trap;
    logic               wr_ok;
    logic [31:0]        cause_rd;

`ifdef CP0_TIMER_EN
    logic [31:0]        count_q;
    logic [31:0]        compare_q;
    logic               timer_match;
`endif

    // Live interrupt lines plus the timer pending bit.
    always_comb begin
        ip_next = bus.hw_int;
`ifdef CP0_TIMER_EN
        ip_next[TIMER_IRQ] = bus.hw_int[TIMER_IRQ] | ti_q;
`endif
    end

    // Trap arbitration; EXL masks both sources so eret never meets a trap.
    always_comb begin
        irq   = sr_q[SR_IE] & ~sr_q[SR_EXL] & (|(sr_q[10 +: NUM_IRQ] & ip_next));
        exc   = ~sr_q[SR_EXL] & (bus.exc_code != 5'd0);
        trap  = irq | exc;
        wr_ok = bus.wr_en & ~trap;
    end

    assign bus.int_req = trap;
    assign bus.epc     = epc_q;

    // SR: trap sets EXL; otherwise mtc0 stores, then eret clears EXL.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= 32'd0;
        end else if (trap) begin
            sr_q[SR_EXL] <= 1'b1;
        end else if (wr_ok && bus.wr_addr == REG_SR) begin
            sr_q         <= bus.wr_data;
            sr_q[SR_EXL] <= bus.wr_data[SR_EXL] & ~bus.eret;
        end else if (bus.eret) begin
            sr_q[SR_EXL] <= 1'b0;
        end
    end

    // Cause: IP is re-sampled every cycle; BD/ExcCode only change on a trap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cause_ip_q   <= '0;
            cause_bd_q   <= 1'b0;
            cause_code_q <= 5'd0;
        end else begin
            cause_ip_q <= ip_next;
            if (trap) begin
                cause_bd_q   <= bus.exc_bd;
                cause_code_q <= irq ? 5'd0 : bus.exc_code;
            end
        end
    end

    // EPC: restart address of the trapping instruction, or an mtc0 value.
    always_ff @(posedge clk) begin
        if (reset) begin
            epc_q <= 32'd0;
        end else if (trap) begin
            epc_q <= bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;
        end else if (wr_ok && bus.wr_addr == REG_EPC) begin
            epc_q <= bus.wr_data;
        end
    end

    // BadVAddr: captured only by an address-error exception that wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            badvaddr_q <= 32'd0;
        end else if (trap && !irq &&
                     (bus.exc_code == 5'd4 || bus.exc_code == 5'd5)) begin
            badvaddr_q <= bus.exc_badvaddr;
        end
    end

`ifdef CP0_TIMER_EN
    assign timer_match = (count_q == compare_q) && (compare_q != 32'd0);

    // Count: free-running, an mtc0 load replaces that cycle's increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 32'd0;
        end else if (wr_ok && bus.wr_addr == REG_COUNT) begin
            count_q <= bus.wr_data;
        end else begin
            count_q <= count_q + 32'd1;
        end
    end

    // Compare and the sticky timer pending bit; a Compare write clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
        end else if (wr_ok && bus.wr_addr == REG_COMPARE) begin
            compare_q <= bus.wr_data;
            ti_q      <= 1'b0;
        end else if (timer_match) begin
            ti_q <= 1'b1;
        end
    end
`else
    assign ti_q = 1'b0;
`endif

    // Cause register as seen by mfc0.
    always_comb begin
        cause_rd               = 32'd0;
        cause_rd[31]           = cause_bd_q;
        cause_rd[30]           = ti_q;
        cause_rd[10 +: NUM_IRQ] = cause_ip_q;
        cause_rd[6:2]          = cause_code_q;
    end

    // mfc0 read mux: pre-edge contents, no write bypass.
    always_comb begin
        bus.rd_data = 32'd0;
        case (bus.rd_addr)
            REG_BADVADDR: bus.rd_data = badvaddr_q;
`ifdef CP0_TIMER_EN
            REG_COUNT:    bus.rd_data = count_q;
            REG_COMPARE:  bus.rd_data = compare_q;
`endif
            REG_SR:       bus.rd_data = sr_q;
            REG_CAUSE:    bus.rd_data = cause_rd;
            REG_EPC:      bus.rd_data = epc_q;
            REG_PRID:     bus.rd_data = PRID_VAL;
            default:      bus.rd_data = 32'd0;
        endcase
    end
endmodule
